audio_tone_synth: RTL and testbench
===================================

// Module: audio_tone_synth
// PURPOSE
//  Mono square-wave tone/sound-effect generator feeding the codec controller's
//  dacdata_left/dacdata_right inputs. Game logic requests a tone with a pitch,
//  an amplitude and a duration. The block then produces one signed 16-bit PCM
//  sample per codec frame, paced by AUD_DACLRCK. It returns to silence and
//  pulses done when the tone ends.
// PARAMETERS
//  PHASE_W      16  phase accumulator width; play_freq = phase step per sample
//  DUR_W        16  duration counter width, in samples
//  DECAY_SHIFT  4   SFX_DECAY_EN only: amplitude drops 1 LSB every 2**DECAY_SHIFT samples
// PORTS
//  CLOCK31_5      in   1        system clock (same clock that drives AUD_XCK)
//  reset          in   1        synchronous reset, active-high
//  AUD_DACLRCK    in   1        codec DAC LR clock, asynchronous to CLOCK31_5
//  play_req       in   1        1-cycle request; play_* fields are sampled in the same cycle
//  play_freq      in   PHASE_W  phase increment per sample (0 = DC, no toggling)
//  play_amp       in   15       unsigned peak amplitude
//  play_dur       in   DUR_W    tone length in samples
//  play_ack       out  1        1-cycle pulse: request accepted
//  busy           out  1        high while in PLAY
//  done           out  1        1-cycle pulse: tone completed naturally
//  dacdata_left   out  16       signed PCM sample to the codec controller
//  dacdata_right  out  16       identical to dacdata_left (mono)
// BEHAVIOUR
//  - Reset values: dacdata_* = 0, busy = 0, play_ack = 0, done = 0.
//    Internally: phase = 0, remaining = 0, state = IDLE.
//  - AUD_DACLRCK passes through a 2-FF synchronizer and a rising-edge detector.
//    The detector gives sample_tick, a 1-cycle pulse.
//    Latency: LRCK rising edge at the pin -> sample_tick on the 3rd CLOCK31_5 edge.
//    The new dacdata_* value is registered on the 4th edge.
//  - dacdata_* change only on the cycle after a sample_tick, or on a state exit.
//    They hold their value between ticks.
//  - FSM IDLE:
//    - play_req -> latch freq/amp/dur; phase <= 0; play_ack = 1 next cycle.
//    - If play_dur = 0: stay in IDLE and pulse done next cycle. No sample is emitted.
//    - Otherwise: remaining <= play_dur; go to PLAY; busy = 1.
//  - FSM PLAY, on each sample_tick:
//    - phase <= phase + freq, modulo 2**PHASE_W (wraps silently).
//    - remaining <= remaining - 1.
//    - sample = phase_new[PHASE_W-1] ? -amp : +amp.
//      amp is zero-extended to 16 bits; -amp is the two's complement.
//      The range is +/-32767, so it never overflows.
//    - On the tick where remaining goes 1 -> 0: emit that last sample.
//      On the next tick, dacdata_* <= 0, state <= IDLE, busy <= 0, done pulses.
//      A tone of N samples therefore produces exactly N non-silent ticks.
//  - play_req during PLAY (retrigger): new fields latched, phase <= 0, play_ack pulses.
//    remaining is reloaded and the block stays in PLAY. No done pulse.
//    play_dur = 0 on retrigger -> IDLE, dacdata_* <= 0, done pulses.
//  - play_req coinciding with the terminating tick: the retrigger wins.
//    No done pulse; the new tone starts.
//  - play_req coinciding with sample_tick in PLAY: the retrigger is applied first.
//    The tick is consumed using the new fields with phase = 0, so the sample = +amp.
//  - Synchronous reset mid-tone: all outputs are 0 on the next cycle.
//    The in-flight tone is discarded without a done pulse.
// CONFIGURATION
//  SFX_DECAY_EN defined:
//    - An envelope register env is loaded with play_amp on accept/retrigger.
//    - env decrements by 1 every 2**DECAY_SHIFT sample_ticks and saturates at 0.
//    - The sample uses env in place of amp.
//    - The tone still ends on duration only, even if env has reached 0.
//  SFX_DECAY_EN undefined:
//    - Amplitude is constant at the latched play_amp.
//    - No envelope logic is synthesized.
// TESTING
//  1. Reset held for 5 cycles, with LRCK toggling.
//     -> dacdata_* = 0, busy = 0, play_ack = 0, done = 0 throughout.
//  2. play_freq = 16'h4000, play_amp = 1000, play_dur = 8.
//     -> Samples are +1000,-1000,-1000,+1000,+1000,-1000,-1000,+1000.
//     -> Then 0, with done pulsed once and busy low.
//  3. play_dur = 0 -> play_ack then done on consecutive cycles.
//     -> busy never rises and dacdata_* stay 0.
//  4. play_freq = 16'hFFFF, play_amp = 15'h7FFF, play_dur = 3.
//     -> Phase wraps with MSB = 1,1,1, so samples are -32767 (16'h8001) x3, then 0.
//  5. Retrigger with amp = 200 during the 4th sample of a dur = 10 tone, in the same cycle as a tick.
//     -> The tick sample = +200; 10 further samples follow; exactly one done at the end.
//  6. With SFX_DECAY_EN, DECAY_SHIFT = 1, amp = 3, freq = 0, dur = 8.
//     -> Samples are 3,3,2,2,1,1,0,0, then done.
//     -> Without the macro, the same stimulus gives eight samples of 3.

Source files
------------

// File: rtl/audio_tone_synth.sv
// rtl/audio_tone_synth.sv - mono square-wave tone generator paced by the codec DAC LR clock
// Optional envelope decay build: define SFX_DECAY_EN (adds DECAY_SHIFT parameter).
module audio_tone_synth #(
  parameter int PHASE_W = 16,
  parameter int DUR_W   = 16
`ifdef SFX_DECAY_EN
  ,
  parameter int DECAY_SHIFT = 4
`endif
) (
  input  logic               CLOCK31_5,
  input  logic               reset,
  input  logic               AUD_DACLRCK,
  input  logic               play_req,
  input  logic [PHASE_W-1:0] play_freq,
  input  logic [14:0]        play_amp,
  input  logic [DUR_W-1:0]   play_dur,
  output logic               play_ack,
  output logic               busy,
  output logic               done,
  output logic [15:0]        dacdata_left,
  output logic [15:0]        dacdata_right
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state;
  logic               lrck_s1, lrck_s2, lrck_s3;
  logic               sample_tick;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq;
  logic [PHASE_W-1:0] phase_new;
  logic [DUR_W-1:0]   remaining;
  logic               zero_pend;
  logic               advance;
  logic [14:0]        level;

  function automatic logic [15:0] to_pcm(input logic neg, input logic [14:0] mag);
    logic [15:0] m;
    m = {1'b0, mag};
    return neg ? (~m + 16'd1) : m;
  endfunction

  // LRCK is asynchronous: two flops to resynchronise, third for the edge detect.
  always_ff @(posedge CLOCK31_5) begin
    if (reset) begin
      lrck_s1     <= 1'b0;
      lrck_s2     <= 1'b0;
      lrck_s3     <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      lrck_s1     <= AUD_DACLRCK;
      lrck_s2     <= lrck_s1;
      lrck_s3     <= lrck_s2;
      sample_tick <= lrck_s2 & ~lrck_s3;
    end
  end

  assign phase_new     = phase + freq;
  assign dacdata_right = dacdata_left;
  assign advance       = (state == PLAY) && sample_tick && !play_req && (remaining != '0);

`ifdef SFX_DECAY_EN
  localparam int DIV_W = (DECAY_SHIFT > 0) ? DECAY_SHIFT : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((1 << DECAY_SHIFT) - 1);

  logic [14:0]      env;
  logic [DIV_W-1:0] div_cnt;

  // The sample on a tick uses env before that tick's decrement.
  always_ff @(posedge CLOCK31_5) begin
    if (reset) begin
      env     <= '0;
      div_cnt <= '0;
    end else if (play_req) begin
      env     <= play_amp;
      div_cnt <= '0;
    end else if (advance) begin
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        if (env != '0) env <= env - 15'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign level = env;
`else
  logic [14:0] amp;

  always_ff @(posedge CLOCK31_5) begin
    if (reset) begin
      amp <= '0;
    end else if (play_req) begin
      amp <= play_amp;
    end
  end

  assign level = amp;
`endif

  always_ff @(posedge CLOCK31_5) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      freq         <= '0;
      remaining    <= '0;
      dacdata_left <= '0;
      busy         <= 1'b0;
      play_ack     <= 1'b0;
      done         <= 1'b0;
      zero_pend    <= 1'b0;
    end else begin
      play_ack  <= play_req;
      done      <= zero_pend;
      zero_pend <= 1'b0;
      if (play_req) begin
        freq      <= play_freq;
        phase     <= '0;
        remaining <= play_dur;
        if (play_dur == '0) begin
          zero_pend    <= 1'b1;
          state        <= IDLE;
          busy         <= 1'b0;
          dacdata_left <= '0;
        end else begin
          state <= PLAY;
          busy  <= 1'b1;
          // A retrigger landing on a tick consumes it at phase 0, i.e. +amp.
          if (state == PLAY && sample_tick) dacdata_left <= to_pcm(1'b0, play_amp);
        end
      end else if (state == PLAY && sample_tick) begin
        if (remaining == '0) begin
          dacdata_left <= '0;
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b1;
        end else begin
          phase        <= phase_new;
          remaining    <= remaining - DUR_W'(1);
          dacdata_left <= to_pcm(phase_new[PHASE_W-1], level);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_tone_synth.sv
// tb/tb_audio_tone_synth.sv - directed table-driven bench for audio_tone_synth
module tb_audio_tone_synth;

  logic        clk = 1'b0;
  logic        reset;
  logic        lrck;
  logic        play_req;
  logic [15:0] play_freq;
  logic [14:0] play_amp;
  logic [15:0] play_dur;
  logic        play_ack;
  logic        busy;
  logic        done;
  logic [15:0] dl;
  logic [15:0] dr;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;

  always #5 clk = ~clk;

  audio_tone_synth #(
    .PHASE_W(16),
    .DUR_W(16)
`ifdef SFX_DECAY_EN
    ,
    .DECAY_SHIFT(1)
`endif
  ) dut (
    .CLOCK31_5(clk),
    .reset(reset),
    .AUD_DACLRCK(lrck),
    .play_req(play_req),
    .play_freq(play_freq),
    .play_amp(play_amp),
    .play_dur(play_dur),
    .play_ack(play_ack),
    .busy(busy),
    .done(done),
    .dacdata_left(dl),
    .dacdata_right(dr)
  );

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [15:0]       freq;
    logic [14:0]       amp;
    logic [15:0]       dur;
    logic [9:0][15:0]  exp;
  } vec_t;

  vec_t vt [3];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_tone(input logic [15:0] f, input logic [14:0] a, input logic [15:0] d);
    play_freq = f;
    play_amp  = a;
    play_dur  = d;
    play_req  = 1'b1;
    cyc(1);
    play_req  = 1'b0;
    check("play_ack", {31'd0, play_ack}, 32'd1);
  endtask

  task automatic tick_expect(input string name, input logic [15:0] exp);
    lrck = 1'b1;
    cyc(4);
    check(name, {dl, dr}, {exp, exp});
    lrck = 1'b0;
    cyc(3);
    check({name, "_hold"}, {16'd0, dl}, {16'd0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    lrck      = 1'b0;
    play_req  = 1'b0;
    play_freq = '0;
    play_amp  = '0;
    play_dur  = '0;

    vt[0].freq = 16'h4000; vt[0].amp = 15'd1000; vt[0].dur = 16'd8; vt[0].exp = '0;
    vt[0].exp[0] = 16'd1000; vt[0].exp[1] = 16'hFC18; vt[0].exp[2] = 16'hFC18; vt[0].exp[3] = 16'd1000;
    vt[0].exp[4] = 16'd1000; vt[0].exp[5] = 16'hFC18; vt[0].exp[6] = 16'hFC18; vt[0].exp[7] = 16'd1000;
    vt[1].freq = 16'hFFFF; vt[1].amp = 15'h7FFF; vt[1].dur = 16'd3; vt[1].exp = '0;
    vt[1].exp[0] = 16'h8001; vt[1].exp[1] = 16'h8001; vt[1].exp[2] = 16'h8001;
    vt[2].freq = 16'h0000; vt[2].amp = 15'd3; vt[2].dur = 16'd8; vt[2].exp = '0;
`ifdef SFX_DECAY_EN
    vt[2].exp[0] = 16'd3; vt[2].exp[1] = 16'd3; vt[2].exp[2] = 16'd2; vt[2].exp[3] = 16'd2;
    vt[2].exp[4] = 16'd1; vt[2].exp[5] = 16'd1; vt[2].exp[6] = 16'd0; vt[2].exp[7] = 16'd0;
`else
    for (int i = 0; i < 8; i++) vt[2].exp[i] = 16'd3;
`endif

    // Reset held with LRCK toggling
    for (int i = 0; i < 5; i++) begin
      lrck = ~lrck;
      cyc(1);
      check("reset_outputs", {dl, dr}, 32'd0);
      check("reset_flags", {29'd0, busy, play_ack, done}, 32'd0);
    end
    reset = 1'b0;
    lrck  = 1'b0;
    cyc(3);

    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt;
      start_tone(vt[v].freq, vt[v].amp, vt[v].dur);
      check("busy_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i < int'(vt[v].dur); i++) tick_expect($sformatf("v%0d_s%0d", v, i), vt[v].exp[i]);
      tick_expect($sformatf("v%0d_end", v), 16'd0);
      check("busy_end", {31'd0, busy}, 32'd0);
      check("done_once", done_cnt - d0, 32'd1);
    end

    // Zero duration: ack then done, never busy
    d0 = done_cnt;
    play_dur = 16'd0; play_amp = 15'd500; play_freq = 16'h1234;
    play_req = 1'b1;
    cyc(1);
    play_req = 1'b0;
    check("zd_c1", {29'd0, play_ack, done, busy}, {29'd0, 3'b100});
    cyc(1);
    check("zd_c2", {29'd0, play_ack, done, busy}, {29'd0, 3'b010});
    cyc(1);
    check("zd_c3", {15'd0, done, dl}, 32'd0);
    check("zd_done_cnt", done_cnt - d0, 32'd1);
    tick_expect("zd_silent", 16'd0);

    // Retrigger coinciding with the 4th tick of a 10-sample tone
    d0 = done_cnt;
    start_tone(16'h4000, 15'd1000, 16'd10);
    tick_expect("rt_s0", 16'd1000);
    tick_expect("rt_s1", 16'hFC18);
    tick_expect("rt_s2", 16'hFC18);
    lrck = 1'b1;
    cyc(3);
    play_freq = 16'h4000; play_amp = 15'd200; play_dur = 16'd10;
    play_req  = 1'b1;
    cyc(1);
    play_req  = 1'b0;
    check("rt_ack", {31'd0, play_ack}, 32'd1);
    check("rt_tick_sample", {16'd0, dl}, 32'd200);
    lrck = 1'b0;
    cyc(3);
    for (int i = 0; i < 10; i++)
      tick_expect($sformatf("rt_n%0d", i), (i % 4 == 1 || i % 4 == 2) ? 16'hFF38 : 16'd200);
    tick_expect("rt_end", 16'd0);
    check("rt_busy_end", {31'd0, busy}, 32'd0);
    check("rt_done_once", done_cnt - d0, 32'd1);

    // Reset mid-tone discards the tone without done
    d0 = done_cnt;
    start_tone(16'h4000, 15'd500, 16'd5);
    tick_expect("mr_s0", 16'd500);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mr_outputs", {dl, dr}, 32'd0);
    check("mr_flags", {29'd0, busy, play_ack, done}, 32'd0);
    cyc(3);
    check("mr_no_done", done_cnt - d0, 32'd0);
    tick_expect("mr_silent", 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
